// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU core: opcodes, ALU operations, control FSM
// states, PC source select encodings and the IR field positions used by both
// the datapath and the control unit.
package cpu_pkg;

    // IR field positions (16-bit instruction word)
    localparam int IR_W       = 16;
    localparam int IR_OP_HI   = 15;
    localparam int IR_OP_LO   = 12;
    localparam int IR_RD_HI   = 11;
    localparam int IR_RD_LO   = 9;
    localparam int IR_RS1_HI  = 8;
    localparam int IR_RS1_LO  = 6;
    localparam int IR_IMM6_HI = 5;
    localparam int IR_IMM6_LO = 0;
    localparam int IR_IMM12_HI = 11;
    localparam int IR_IMM12_LO = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_ADDI = 4'h5,
        OP_LW   = 4'h6,
        OP_SW   = 4'h7,
        OP_BEQ  = 4'h8,
        OP_JMP  = 4'h9,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_e;

    // FSM state codes kept as plain constants for legacy netlists and debug
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM_RD = 3'd3;
    localparam logic [2:0] ST_MEM_WR = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_BR     = 3'd6;
    localparam logic [2:0] ST_HALT   = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM_RD = ST_MEM_RD,
        S_MEM_WR = ST_MEM_WR,
        S_WB     = ST_WB,
        S_BR     = ST_BR,
        S_HALT   = ST_HALT
    } state_e;

    // PC source select
    localparam logic [1:0] PC_SEL_INC = 2'd0;  // PC + 1
    localparam logic [1:0] PC_SEL_BR  = 2'd1;  // PC + sext(imm6)
    localparam logic [1:0] PC_SEL_JMP = 2'd2;  // sext(imm12)

    // Opcodes 0-9 and F are defined; A-E are illegal
    function automatic logic is_legal(input logic [3:0] op);
        return (op <= 4'h9) || (op == 4'hF);
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle control FSM for the CPU core datapath. Sequences fetch, decode,
// execute, memory and write-back, drives every datapath enable/select, and
// reports halt, sticky illegal-opcode and a retired-instruction count.
//
// Handshake: there is no valid/ready pair here. `run` acts as a level-sensitive
// start qualifier: it is looked at only while in FETCH, and once an instruction
// has begun it always runs to completion regardless of `run`.
module control_unit
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             flag_z,
    output logic             pc_en,
    output logic             ir_en,
    output logic             a_en,
    output logic             b_en,
    output logic             acc_en,
    output logic             mar_en,
    output logic             mdr_en,
    output logic             flags_en,
    output logic             rf_we,
    output logic             ram_we,
    output logic [1:0]       pc_sel,
    output logic             alu_b_sel,
    output logic [2:0]       alu_op,
    output logic             rf_wd_sel,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_dbg
);

    state_e           state_q;
    state_e           state_d;
    logic [3:0]       op_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             illegal_set;

    // Next-state, retirement and illegal-detect decode
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        illegal_set = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run) state_d = S_DECODE;
            end
            S_DECODE: begin
                // The live opcode is used here; it is captured for later states
                if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else if (!is_legal(opcode)) begin
                    state_d     = S_HALT;
                    illegal_set = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_LW:   state_d = S_MEM_RD;
                    OP_SW:   state_d = S_MEM_WR;
                    OP_BEQ:  state_d = S_BR;
                    OP_JMP: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM_RD: state_d = S_WB;
            S_MEM_WR: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BR: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // State, captured opcode, sticky illegal flag and retirement counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= 4'h0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= opcode;
            if (illegal_set) illegal_q <= 1'b1;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Moore output decode from state and captured opcode; BR pc_en also
    // follows flag_z, and FETCH strobes are qualified by run
    always_comb begin
        pc_en     = 1'b0;
        ir_en     = 1'b0;
        a_en      = 1'b0;
        b_en      = 1'b0;
        acc_en    = 1'b0;
        mar_en    = 1'b0;
        mdr_en    = 1'b0;
        flags_en  = 1'b0;
        rf_we     = 1'b0;
        ram_we    = 1'b0;
        pc_sel    = PC_SEL_INC;
        alu_b_sel = 1'b0;
        alu_op    = ALU_ADD;
        rf_wd_sel = 1'b0;
        case (state_q)
            S_FETCH: begin
                // rst gate keeps the strobes low while reset is held
                ir_en = run & ~rst;
                pc_en = run & ~rst;
            end
            S_DECODE: begin
                a_en = 1'b1;
                b_en = 1'b1;
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        alu_op   = op_q[2:0];
                        acc_en   = 1'b1;
                        flags_en = 1'b1;
                    end
                    OP_ADDI: begin
                        alu_b_sel = 1'b1;
                        acc_en    = 1'b1;
                        flags_en  = 1'b1;
                    end
                    OP_LW, OP_SW: begin
                        alu_b_sel = 1'b1;
                        mar_en    = 1'b1;
                    end
                    OP_BEQ: begin
                        alu_op   = ALU_SUB;
                        flags_en = 1'b1;
                    end
                    OP_JMP: begin
                        pc_en  = 1'b1;
                        pc_sel = PC_SEL_JMP;
                    end
                    default: ;
                endcase
            end
            S_MEM_RD: mdr_en = 1'b1;
            S_MEM_WR: ram_we = 1'b1;
            S_WB: begin
                rf_we     = 1'b1;
                rf_wd_sel = (op_q == OP_LW);
            end
            S_BR: begin
                pc_en  = flag_z;
                pc_sel = PC_SEL_BR;
            end
            default: ;
        endcase
    end

    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;
    assign retired   = retired_q;
    assign state_dbg = state_q;

endmodule
